// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit
//   Instruction fetch stage feeding the CPU control FSM. Owns the program
//   counter, issues one read at a time to a synchronous program RAM,
//   registers the returned word and hands it over with valid/ready. Absolute
//   redirects from the FSM reload the PC and discard any read in flight.
//
//   Optional feature macro: FETCH_PERF_CNT_EN
//     defined   -> fetch_count / flush_count are live saturating counters
//     undefined -> both counters are tied to zero
//
// Ports
//   clk            clock, all state on posedge
//   reset          asynchronous, active-low
//   fetch_en       FSM permits new fetches
//   redirect_valid load PC from redirect_addr (highest priority)
//   redirect_addr  absolute target PC
//   mem_addr       program RAM read address (holds outside ISSUE)
//   mem_rd_en      registered one-cycle read strobe
//   mem_rdata      program RAM read data
//   instr_out      registered instruction word
//   instr_pc       address instr_out was fetched from
//   instr_valid    instr_out holds an unconsumed instruction
//   instr_ready    FSM accepts instr_out this cycle
//   fetch_count    delivered-instruction counter
//   flush_count    discarded-read counter
module cpu_fetch_unit #(
  parameter int          DATA_WIDTH  = 16,
  parameter int          ADDR_WIDTH  = 10,
  parameter int unsigned RESET_PC    = 0,
  parameter int          MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [15:0]           fetch_count,
  output logic [15:0]           flush_count
);

  localparam logic [ADDR_WIDTH-1:0] PC_INIT  = ADDR_WIDTH'(RESET_PC);
  localparam logic [1:0]            LAT_LOAD = 2'(MEM_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   pc, pc_next;
  logic [1:0]              lat_cnt;
  logic                    capture;
  logic                    handshake;

  // instr_valid is only ever high in HOLD, so this is the HOLD acceptance.
  assign handshake = instr_valid && instr_ready;

  // Next-state / next-PC. A redirect overrides everything, including a
  // same-cycle handshake: the word is consumed but the PC takes the target.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    if (redirect_valid) begin
      pc_next    = redirect_addr;
      state_next = fetch_en ? ST_ISSUE : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (fetch_en) state_next = ST_ISSUE;
        ST_ISSUE: state_next = ST_WAIT;
        // Capture on the edge where the counter would reach zero, so the
        // WAIT state lasts exactly MEM_LATENCY cycles.
        ST_WAIT: begin
          if (lat_cnt == 2'd1) begin
            capture    = 1'b1;
            state_next = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            pc_next    = pc + ADDR_WIDTH'(1);
            state_next = fetch_en ? ST_ISSUE : ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // The strobe and address are registered from the next state, so mem_rd_en
  // is high for exactly the cycles spent in ISSUE and never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pc          <= PC_INIT;
      mem_rd_en   <= 1'b0;
      mem_addr    <= PC_INIT;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      lat_cnt     <= '0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      mem_rd_en <= (state_next == ST_ISSUE);
      if (state_next == ST_ISSUE) mem_addr <= pc_next;

      if (state == ST_ISSUE)
        lat_cnt <= LAT_LOAD;
      else if (state == ST_WAIT && lat_cnt != 2'd0)
        lat_cnt <= lat_cnt - 2'd1;

      if (capture) begin
        instr_out <= mem_rdata;
        instr_pc  <= pc;
      end

      if (redirect_valid)
        instr_valid <= 1'b0;
      else if (capture)
        instr_valid <= 1'b1;
      else if (handshake)
        instr_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic discard;

  // Only a redirect that kills a strobe or a pending response is a flush.
  assign discard = redirect_valid && (state == ST_ISSUE || state == ST_WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (handshake && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      if (discard && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
  end
`else
  assign fetch_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit. Two lanes: lane 0 uses MEM_LATENCY=1 and runs
// the directed scenarios, lane 1 uses MEM_LATENCY=3; both then get a random
// sweep. Each lane has a RAM model and a scoreboard holding the address of
// the next instruction the FSM should receive.
module tb_cpu_fetch_unit;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [9:0] a);
    return 16'h1001 + 16'(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        fetch_en       = 1'b0;
    logic        redirect_valid = 1'b0;
    logic        instr_ready    = 1'b0;
    logic [9:0]  redirect_addr  = '0;
    logic [9:0]  mem_addr, instr_pc;
    logic        mem_rd_en, instr_valid;
    logic [15:0] mem_rdata, instr_out, fetch_count, flush_count;
    logic [15:0] rd_pipe [LAT];

    logic [9:0]  frontPc     = '0;
    logic        outstanding = 1'b0;
    logic        armed       = 1'b0;
    logic        prevValid   = 1'b0;
    int          since       = 0;
    int          expFetch    = 0;
    int          expFlush    = 0;

    cpu_fetch_unit #(.MEM_LATENCY(LAT)) dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_en      (fetch_en),
      .redirect_valid(redirect_valid),
      .redirect_addr (redirect_addr),
      .mem_addr      (mem_addr),
      .mem_rd_en     (mem_rd_en),
      .mem_rdata     (mem_rdata),
      .instr_out     (instr_out),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .fetch_count   (fetch_count),
      .flush_count   (flush_count)
    );

    // Synchronous RAM: address sampled with the strobe, data valid LAT edges later.
    always @(posedge clk) begin
      rd_pipe[0] <= mem_rd_en ? memWord(mem_addr) : 16'hBAD0;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // Scoreboard: at each negedge, compare outputs against the expected next
    // instruction, then apply the inputs that the coming posedge will see.
    initial begin : mon
      logic hs;
      forever begin
        @(negedge clk);
        if (!reset) begin
          frontPc = '0; outstanding = 1'b0; armed = 1'b0; prevValid = 1'b0;
          since = 0; expFetch = 0; expFlush = 0;
        end else begin
          since++;
          if (mem_rd_en) begin
            checkOutput("fetch_addr", 32'(mem_addr), 32'(frontPc));
            checkOutput("no_overlap", 32'(instr_valid), 32'd0);
          end
          if (instr_valid && !prevValid) begin
            checkOutput("valid_after_read", 32'(armed), 32'd1);
            if (armed) checkOutput("latency", since, LAT + 1);
            armed = 1'b0;
          end
          hs = instr_valid && instr_ready;
          if (hs) begin
            checkOutput("hs_pc", 32'(instr_pc), 32'(frontPc));
            checkOutput("hs_data", 32'(instr_out), 32'(memWord(frontPc)));
            expFetch++;
            frontPc = frontPc + 10'd1;
          end
          if (mem_rd_en) begin
            armed = 1'b1; since = 0; outstanding = 1'b1;
          end
          if (instr_valid) outstanding = 1'b0;
          if (redirect_valid) begin
            if (mem_rd_en || outstanding) expFlush++;
            frontPc = redirect_addr; armed = 1'b0; outstanding = 1'b0;
          end
          prevValid = instr_valid;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int lane, input logic fe, input logic rv,
                               input logic [9:0] ra, input logic rdy);
    if (lane == 0) begin
      g_lane[0].fetch_en = fe; g_lane[0].redirect_valid = rv;
      g_lane[0].redirect_addr = ra; g_lane[0].instr_ready = rdy;
    end else begin
      g_lane[1].fetch_en = fe; g_lane[1].redirect_valid = rv;
      g_lane[1].redirect_addr = ra; g_lane[1].instr_ready = rdy;
    end
  endtask

  task automatic checkCounters(input int lane);
    logic [15:0] fc, lc;
    int ef, el;
    if (lane == 0) begin
      fc = g_lane[0].fetch_count; lc = g_lane[0].flush_count;
      ef = g_lane[0].expFetch;    el = g_lane[0].expFlush;
    end else begin
      fc = g_lane[1].fetch_count; lc = g_lane[1].flush_count;
      ef = g_lane[1].expFetch;    el = g_lane[1].expFlush;
    end
`ifdef FETCH_PERF_CNT_EN
    checkOutput("fetch_count", 32'(fc), ef);
    checkOutput("flush_count", 32'(lc), el);
`else
    checkOutput("fetch_count_tied", 32'(fc), 32'(ef * 0));
    checkOutput("flush_count_tied", 32'(lc), 32'(el * 0));
`endif
  endtask

  task automatic checkResetValues(input int lane);
    logic rd, v;
    logic [9:0] a, p;
    logic [15:0] o, fc, lc;
    if (lane == 0) begin
      rd = g_lane[0].mem_rd_en; v = g_lane[0].instr_valid; a = g_lane[0].mem_addr;
      p = g_lane[0].instr_pc; o = g_lane[0].instr_out;
      fc = g_lane[0].fetch_count; lc = g_lane[0].flush_count;
    end else begin
      rd = g_lane[1].mem_rd_en; v = g_lane[1].instr_valid; a = g_lane[1].mem_addr;
      p = g_lane[1].instr_pc; o = g_lane[1].instr_out;
      fc = g_lane[1].fetch_count; lc = g_lane[1].flush_count;
    end
    checkOutput("rst_rd_en", 32'(rd), 32'd0);
    checkOutput("rst_valid", 32'(v), 32'd0);
    checkOutput("rst_mem_addr", 32'(a), 32'd0);
    checkOutput("rst_instr_pc", 32'(p), 32'd0);
    checkOutput("rst_instr_out", 32'(o), 32'd0);
    checkOutput("rst_fetch_count", 32'(fc), 32'd0);
    checkOutput("rst_flush_count", 32'(lc), 32'd0);
  endtask

  // Lane 0 waits, bounded; a timeout is reported as a failed comparison.
  task automatic waitStrobe(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!g_lane[0].mem_rd_en && n < 40);
    checkOutput(tag, 32'(g_lane[0].mem_rd_en), 32'd1);
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!g_lane[0].instr_valid && n < 40);
    checkOutput(tag, 32'(g_lane[0].instr_valid), 32'd1);
  endtask

  initial begin
    int strobes;

    // Reset state on both lanes.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues(0);
    checkResetValues(1);

    // Sequential fetch from 0 with ready held high.
    tick();
    applyStimulus(0, 1'b1, 1'b0, 10'd0, 1'b1);
    reset = 1'b1;
    waitValid("t1_wait_valid");
    checkOutput("t1_first_pc", 32'(g_lane[0].instr_pc), 32'd0);
    checkOutput("t1_first_data", 32'(g_lane[0].instr_out), 32'h1001);
    repeat (12) tick();
    checkOutput("t1_delivered", 32'(g_lane[0].expFetch >= 4), 32'd1);
    checkCounters(0);

    // Back-pressure while holding the word fetched from pc=7.
    applyStimulus(0, 1'b1, 1'b1, 10'd7, 1'b0);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 10'd0, 1'b0);
    waitValid("t2_wait_valid");
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t2_hold_pc", 32'(g_lane[0].instr_pc), 32'd7);
      checkOutput("t2_hold_data", 32'(g_lane[0].instr_out), 32'h1008);
      if (g_lane[0].mem_rd_en) strobes++;
    end
    checkOutput("t2_no_strobe", strobes, 0);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 10'd0, 1'b1);
    waitStrobe("t2_wait_strobe");
    checkOutput("t2_next_addr", 32'(g_lane[0].mem_addr), 32'd8);

    // Redirect while the read of 8 is pending in WAIT.
    tick();
    applyStimulus(0, 1'b1, 1'b1, 10'h200, 1'b1);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 10'd0, 1'b1);
    checkCounters(0);
    @(negedge clk);
    checkOutput("t3_stale_valid", 32'(g_lane[0].instr_valid), 32'd0);
    checkOutput("t3_rd_en", 32'(g_lane[0].mem_rd_en), 32'd1);
    checkOutput("t3_addr", 32'(g_lane[0].mem_addr), 32'h200);

    // PC wrap from 1023, then redirect together with acceptance at pc=5.
    tick();
    applyStimulus(0, 1'b1, 1'b1, 10'h3FF, 1'b1);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 10'd0, 1'b1);
    waitValid("t4_wait_valid_wrap");
    checkOutput("t4_pc_3ff", 32'(g_lane[0].instr_pc), 32'h3FF);
    waitStrobe("t4_wait_strobe_wrap");
    checkOutput("t4_wrap_addr", 32'(g_lane[0].mem_addr), 32'd0);
    tick();
    applyStimulus(0, 1'b1, 1'b1, 10'd5, 1'b0);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 10'd0, 1'b0);
    waitValid("t4_wait_valid_5");
    checkOutput("t4_pc_5", 32'(g_lane[0].instr_pc), 32'd5);
    tick();
    applyStimulus(0, 1'b1, 1'b1, 10'h40, 1'b1);
    tick();
    applyStimulus(0, 1'b1, 1'b0, 10'd0, 1'b0);
    checkCounters(0);
    waitStrobe("t4_wait_strobe_40");
    checkOutput("t4_addr_40", 32'(g_lane[0].mem_addr), 32'h40);

    // Drop fetch_en during ISSUE: word still delivered, then stay idle.
    #1 g_lane[0].fetch_en = 1'b0;
    waitValid("t5_wait_valid");
    checkOutput("t5_pc", 32'(g_lane[0].instr_pc), 32'h40);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 10'd0, 1'b1);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 10'd0, 1'b0);
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (g_lane[0].mem_rd_en) strobes++;
    end
    checkOutput("t5_idle_no_strobe", strobes, 0);
    checkOutput("t5_idle_valid", 32'(g_lane[0].instr_valid), 32'd0);
    checkCounters(0);

    // Asynchronous reset in WAIT: outputs clear without a clock edge.
    tick();
    applyStimulus(0, 1'b1, 1'b0, 10'd0, 1'b0);
    waitStrobe("t5_wait_strobe");
    tick();
    #2 reset = 1'b0;
    #1 checkResetValues(0);
    tick();
    tick();
    reset = 1'b1;

    // Random sweep on both lanes.
    for (int c = 0; c < 800; c++) begin
      tick();
      for (int l = 0; l < 2; l++)
        applyStimulus(l, $urandom_range(0, 7) != 0, $urandom_range(0, 11) == 0,
                      ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom),
                      $urandom_range(0, 2) != 0);
    end
    tick();
    applyStimulus(0, 1'b1, 1'b0, 10'd0, 1'b1);
    applyStimulus(1, 1'b1, 1'b0, 10'd0, 1'b1);
    repeat (20) tick();
    checkCounters(0);
    checkCounters(1);
    checkOutput("sweep_progress0", 32'(g_lane[0].expFetch > 30), 32'd1);
    checkOutput("sweep_progress1", 32'(g_lane[1].expFetch > 30), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
